// File: rtl/hbridge_guard.sv
// hbridge_guard: dead-time and shoot-through guard between the PWM peripheral and the H-bridge pins.
// Each side (right = PWM1/H_IN[1:0], left = PWM2/H_IN[3:2]) runs its own OFF/DRIVE/DEAD machine,
// so that both legs of a side are never driven together and every reversal waits DEAD_CYCLES clocks.
// Optional build macro HB_FAULT_LATCH_EN: FAULT becomes sticky and a faulted side is parked in OFF
// until a FAULT_CLR pulse or reset. Without it, FAULT is a per-cycle flag and FAULT_CLR is ignored.
module hbridge_guard #(
   parameter int DEAD_CYCLES = 200,
   parameter int CNT_W       = 16
) (
   input  logic       PCLK,
   input  logic       PRESETN,
   input  logic       PWM1,
   input  logic       PWM2,
   input  logic [3:0] H_IN,
   input  logic       FAULT_CLR,
   output logic       PWM1_OUT,
   output logic       PWM2_OUT,
   output logic [3:0] H_OUT,
   output logic [1:0] DEAD_ACTIVE,
   output logic [1:0] FAULT
);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DEAD  = 2'd2
   } side_state_t;

   // The counter counts DEAD_CYCLES-1 down to 0 inclusive, giving DEAD_CYCLES cycles in DEAD.
   localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

   logic [1:0] pwm_raw;
   wire  [1:0] pwm_gated;
   wire  [3:0] h_gated;
   wire  [1:0] dead_flag;
   wire  [1:0] fault_flag;

   assign pwm_raw = {PWM2, PWM1};

`ifndef HB_FAULT_LATCH_EN
   // FAULT_CLR only matters for the latched-fault build; it stays on the port list regardless.
   logic unused_fault_clr;
   assign unused_fault_clr = FAULT_CLR;
`endif

   generate
      for (genvar s = 0; s < 2; s++) begin : g_side
         side_state_t      state_q, state_d;
         logic [1:0]       cur_q, cur_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic [1:0]       req;
         logic             req_illegal;
         logic             req_drive;
         logic             hold_off;
         logic             pwm_q;
         logic             fault_q, fault_d;
         logic [1:0]       h_o;
         logic             pwm_o;
         logic             dead_o;

         assign req         = H_IN[2*s +: 2];
         assign req_illegal = (req == 2'b11);
         assign req_drive   = (req == 2'b01) || (req == 2'b10);

`ifdef HB_FAULT_LATCH_EN
         assign fault_d  = req_illegal | (fault_q & ~FAULT_CLR);
         assign hold_off = fault_q;
`else
         assign fault_d  = req_illegal;
         assign hold_off = 1'b0;
`endif

         // State register: FSM state, applied code, dead-time counter, PWM sample and fault flag.
         always_ff @(posedge PCLK or negedge PRESETN) begin
            if (!PRESETN) begin
               state_q <= ST_OFF;
               cur_q   <= 2'b00;
               cnt_q   <= '0;
               pwm_q   <= 1'b0;
               fault_q <= 1'b0;
            end else begin
               state_q <= state_d;
               cur_q   <= cur_d;
               cnt_q   <= cnt_d;
               pwm_q   <= pwm_raw[s];
               fault_q <= fault_d;
            end
         end

         // Next-state logic: any departure from the applied code goes through a full dead window.
         always_comb begin
            state_d = state_q;
            cur_d   = cur_q;
            cnt_d   = cnt_q;
            case (state_q)
               ST_OFF: begin
                  if (!hold_off && req_drive) begin
                     state_d = ST_DRIVE;
                     cur_d   = req;
                  end
               end
               ST_DRIVE: begin
                  if ((req != cur_q) || hold_off) begin
                     state_d = ST_DEAD;
                     cur_d   = 2'b00;
                     cnt_d   = DEAD_LOAD;
                  end
               end
               ST_DEAD: begin
                  if (cnt_q == '0) begin
                     if (!hold_off && req_drive) begin
                        state_d = ST_DRIVE;
                        cur_d   = req;
                     end else begin
                        state_d = ST_OFF;
                        cur_d   = 2'b00;
                     end
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
               default: begin
                  state_d = ST_OFF;
                  cur_d   = 2'b00;
                  cnt_d   = '0;
               end
            endcase
         end

         // Output decode: driver pins and PWM only see anything while the side is in DRIVE.
         always_comb begin
            h_o    = 2'b00;
            pwm_o  = 1'b0;
            dead_o = 1'b0;
            case (state_q)
               ST_DRIVE: begin
                  h_o   = cur_q;
                  pwm_o = pwm_q;
               end
               ST_DEAD: begin
                  dead_o = 1'b1;
               end
               default: begin
                  h_o    = 2'b00;
                  pwm_o  = 1'b0;
                  dead_o = 1'b0;
               end
            endcase
         end

         assign h_gated[2*s +: 2] = h_o;
         assign pwm_gated[s]      = pwm_o;
         assign dead_flag[s]      = dead_o;
         assign fault_flag[s]     = fault_q;
      end
   endgenerate

   assign PWM1_OUT    = pwm_gated[0];
   assign PWM2_OUT    = pwm_gated[1];
   assign H_OUT       = h_gated;
   assign DEAD_ACTIVE = dead_flag;
   assign FAULT       = fault_flag;

endmodule

// File: tb/tb_hbridge_guard.sv
// tb_hbridge_guard: self-checking bench for hbridge_guard (default DEAD_CYCLES = 200).
// Honours HB_FAULT_LATCH_EN in its reference model when the build defines it.
`timescale 1ns/1ps
module tb_hbridge_guard;

   localparam int DEAD = 200;
`ifdef HB_FAULT_LATCH_EN
   localparam bit LATCH = 1'b1;
`else
   localparam bit LATCH = 1'b0;
`endif

   logic       PCLK = 1'b0;
   logic       PRESETN;
   logic       PWM1;
   logic       PWM2;
   logic [3:0] H_IN;
   logic       FAULT_CLR;
   logic       PWM1_OUT;
   logic       PWM2_OUT;
   logic [3:0] H_OUT;
   logic [1:0] DEAD_ACTIVE;
   logic [1:0] FAULT;

   int nChecks = 0;
   int nFail   = 0;

   hbridge_guard #(.DEAD_CYCLES(DEAD), .CNT_W(16)) dut (
      .PCLK       (PCLK),
      .PRESETN    (PRESETN),
      .PWM1       (PWM1),
      .PWM2       (PWM2),
      .H_IN       (H_IN),
      .FAULT_CLR  (FAULT_CLR),
      .PWM1_OUT   (PWM1_OUT),
      .PWM2_OUT   (PWM2_OUT),
      .H_OUT      (H_OUT),
      .DEAD_ACTIVE(DEAD_ACTIVE),
      .FAULT      (FAULT)
   );

   // 20 MHz clock
   always #25 PCLK = ~PCLK;

   // Watchdog so a stuck run still ends
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Behavioural model: per side, the applied code (0 = none) and the dead cycles still to show.
   logic [1:0] mApp   [2];
   int         mDead  [2];
   bit         mPwm   [2];
   bit         mFault [2];

   function automatic void modelReset();
      for (int s = 0; s < 2; s++) begin
         mApp[s]   = 2'b00;
         mDead[s]  = 0;
         mPwm[s]   = 1'b0;
         mFault[s] = 1'b0;
      end
   endfunction

   function automatic void modelStep(input logic [3:0] h, input logic p1, input logic p2, input logic clr);
      logic [1:0] req;
      bit         held;
      bit         legalDrive;
      for (int s = 0; s < 2; s++) begin
         req        = (s == 0) ? h[1:0] : h[3:2];
         held       = LATCH && mFault[s];
         legalDrive = (req == 2'b01) || (req == 2'b10);
         if (mDead[s] > 0) begin
            if (mDead[s] == 1) begin
               mDead[s] = 0;
               mApp[s]  = (!held && legalDrive) ? req : 2'b00;
            end else begin
               mDead[s] = mDead[s] - 1;
            end
         end else if (mApp[s] != 2'b00) begin
            if (req != mApp[s] || held) begin
               mApp[s]  = 2'b00;
               mDead[s] = DEAD;
            end
         end else if (!held && legalDrive) begin
            mApp[s] = req;
         end
         if (LATCH) mFault[s] = (req == 2'b11) || (mFault[s] && !clr);
         else       mFault[s] = (req == 2'b11);
      end
      mPwm[0] = p1;
      mPwm[1] = p2;
   endfunction

   function automatic logic [9:0] modelOut();
      logic o1, o2, d0, d1;
      o1 = mPwm[0] && (mApp[0] != 2'b00);
      o2 = mPwm[1] && (mApp[1] != 2'b00);
      d0 = (mDead[0] > 0);
      d1 = (mDead[1] > 0);
      return {o1, o2, mApp[1], mApp[0], d1, d0, mFault[1], mFault[0]};
   endfunction

   function automatic logic [9:0] dutOut();
      return {PWM1_OUT, PWM2_OUT, H_OUT, DEAD_ACTIVE, FAULT};
   endfunction

   task automatic compareVec(input string name, input logic [9:0] act, input logic [9:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %b expected %b (PWM1_OUT,PWM2_OUT,H_OUT,DEAD_ACTIVE,FAULT) at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic compareInt(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a falling edge: drive inputs, advance the model, run one rising edge, return at next falling edge.
   task automatic applyStimulus(input logic [3:0] h, input logic p1, input logic p2, input logic clr);
      H_IN      = h;
      PWM1      = p1;
      PWM2      = p2;
      FAULT_CLR = clr;
      modelStep(h, p1, p2, clr);
      @(posedge PCLK);
      @(negedge PCLK);
   endtask

   task automatic checkOutput(input string name);
      compareVec(name, dutOut(), modelOut());
   endtask

   typedef struct {
      logic [3:0] h;
      logic       p1;
      logic       p2;
      logic [9:0] expOut;
   } vec_t;

   vec_t vecs [6];

   int deadR, deadL, guard, leak, faultCnt, hLeftCnt;
   logic [3:0] hr;
   logic [1:0] rreq;

   initial begin
      // {PWM1_OUT, PWM2_OUT, H_OUT, DEAD_ACTIVE, FAULT} one edge after each row is applied
      vecs[0] = '{h: 4'b0001, p1: 1'b1, p2: 1'b0, expOut: 10'b1_0_0001_00_00};
      vecs[1] = '{h: 4'b0001, p1: 1'b0, p2: 1'b0, expOut: 10'b0_0_0001_00_00};
      vecs[2] = '{h: 4'b0001, p1: 1'b1, p2: 1'b0, expOut: 10'b1_0_0001_00_00};
      vecs[3] = '{h: 4'b0001, p1: 1'b1, p2: 1'b1, expOut: 10'b1_0_0001_00_00};
      vecs[4] = '{h: 4'b0101, p1: 1'b0, p2: 1'b1, expOut: 10'b0_1_0101_00_00};
      vecs[5] = '{h: 4'b0101, p1: 1'b1, p2: 1'b0, expOut: 10'b1_0_0101_00_00};

      // Reset with a drive request already present
      PRESETN   = 1'b0;
      H_IN      = 4'b0001;
      PWM1      = 1'b0;
      PWM2      = 1'b0;
      FAULT_CLR = 1'b0;
      modelReset();
      repeat (3) @(negedge PCLK);
      compareVec("reset_state", dutOut(), 10'b0);
      PRESETN = 1'b1;

      // Pass-through table
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].h, vecs[i].p1, vecs[i].p2, 1'b0);
         compareVec($sformatf("table_%0d", i), dutOut(), vecs[i].expOut);
         checkOutput($sformatf("table_model_%0d", i));
      end

      // Right side reverses 01 -> 10 while left holds 01
      applyStimulus(4'b0110, 1'b1, 1'b1, 1'b0);
      checkOutput("reverse_entry");
      deadR = 0;
      leak  = 0;
      guard = 0;
      while (H_OUT[1:0] == 2'b00 && DEAD_ACTIVE[0] && guard < 1000) begin
         deadR++;
         guard++;
         if (PWM1_OUT) leak++;
         applyStimulus(4'b0110, 1'b1, 1'b1, 1'b0);
         checkOutput("reverse_window");
      end
      compareInt("reverse_dead_len", deadR, DEAD);
      compareInt("reverse_pwm1_leak", leak, 0);
      compareInt("reverse_new_code", int'(H_OUT[1:0]), 2);

      // Request wanders during DEAD; only the value at expiry counts
      applyStimulus(4'b0100, 1'b1, 1'b1, 1'b0);
      checkOutput("wander_entry");
      for (int i = 0; i < DEAD; i++) begin
         rreq = (i < 60) ? 2'b10 : ((i < 120) ? 2'b00 : 2'b01);
         if (i < DEAD - 1) compareInt("wander_dead_active", int'(DEAD_ACTIVE[0]), 1);
         applyStimulus({2'b01, rreq}, 1'b1, 1'b1, 1'b0);
         checkOutput("wander_window");
      end
      compareInt("wander_expiry_code", int'(H_OUT[1:0]), 1);

      // Bring left to idle, then request the illegal code on it for 3 cycles
      for (int i = 0; i < DEAD + 5; i++) begin
         applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0);
         checkOutput("left_idle");
      end
      faultCnt = 0;
      hLeftCnt = 0;
      leak     = 0;
      for (int i = 0; i < 6; i++) begin
         hr = (i < 3) ? 4'b1101 : 4'b0001;
         applyStimulus(hr, 1'b1, 1'b1, 1'b0);
         checkOutput("illegal_left");
         if (FAULT[1]) faultCnt++;
         if (H_OUT[3:2] != 2'b00) hLeftCnt++;
         if (PWM2_OUT) leak++;
      end
      compareInt("illegal_fault_cycles", faultCnt, LATCH ? 6 : 3);
      compareInt("illegal_left_driven", hLeftCnt, 0);
      compareInt("illegal_pwm2_leak", leak, 0);
      applyStimulus(4'b0001, 1'b1, 1'b1, 1'b1);
      checkOutput("fault_clear");
      compareInt("fault_after_clear", int'(FAULT[1]), 0);

      // Both sides driving 01, then both reverse on the same cycle
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0101, 1'b0, 1'b1, 1'b0);
         checkOutput("both_drive");
      end
      compareInt("both_drive_code", int'(H_OUT), 5);
      applyStimulus(4'b1010, 1'b1, 1'b1, 1'b0);
      checkOutput("both_reverse_entry");
      deadR = 0;
      deadL = 0;
      guard = 0;
      while (DEAD_ACTIVE != 2'b00 && guard < 1000) begin
         guard++;
         if (DEAD_ACTIVE[0]) deadR++;
         if (DEAD_ACTIVE[1]) deadL++;
         applyStimulus(4'b1010, 1'b1, 1'b1, 1'b0);
         checkOutput("both_reverse_window");
      end
      compareInt("both_dead_right", deadR, DEAD);
      compareInt("both_dead_left", deadL, DEAD);
      compareInt("both_new_code", int'(H_OUT), 10);

      // Asynchronous reset in the middle of a dead window
      applyStimulus(4'b0101, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 50; i++) begin
         applyStimulus(4'b0101, 1'b1, 1'b1, 1'b0);
         checkOutput("pre_reset_dead");
      end
      compareInt("pre_reset_dead_active", int'(DEAD_ACTIVE), 3);
      #5;
      PRESETN = 1'b0;
      H_IN    = 4'b0110;
      #1;
      compareVec("async_reset_outputs", dutOut(), 10'b0);
      modelReset();
      @(negedge PCLK);
      compareVec("held_reset_outputs", dutOut(), 10'b0);
      PRESETN = 1'b1;
      applyStimulus(4'b0110, 1'b1, 1'b0, 1'b0);
      checkOutput("post_reset_first_edge");
      compareInt("post_reset_code", int'(H_OUT), 6);

      // Randomised run against the model
      hr = 4'b0110;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 63) == 0) hr = 4'($urandom_range(0, 15));
         applyStimulus(hr, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
         checkOutput("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
